// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: conditions the raw clock/data lines, deserializes
// 11-bit frames, checks odd parity and stop bit, and aborts stalled frames.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Odd parity holds when the data bits and the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic [1:0]            sync_c_r;
  logic [1:0]            sync_d_r;
  logic [FILTER_LEN-1:0] filt_sr_r;
  logic                  filt_c_r;
  logic                  filt_prev_r;
  logic                  fall_edge_s;
  logic                  data_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            bit_cnt_r;
  logic [3:0]            bit_cnt_nxt_s;
  logic [TMO_W-1:0]      tmo_cnt_r;
  logic [TMO_W-1:0]      tmo_cnt_nxt_s;
  // Holds the nine most recent samples; the oldest of the ten-bit frame window is dropped.
  logic [8:0]            shreg_r;
  logic [8:0]            shreg_nxt_s;
  logic [9:0]            frame_s;
  logic [7:0]            dout_r;
  logic [7:0]            dout_nxt_s;
  logic                  done_r;
  logic                  done_nxt_s;
  logic                  perr_r;
  logic                  perr_nxt_s;
  logic                  ferr_r;
  logic                  ferr_nxt_s;

  assign data_s      = sync_d_r[1];
  assign fall_edge_s = filt_prev_r & ~filt_c_r;
  assign frame_s     = {data_s, shreg_r};

  // Two-flop synchronizers for the pad inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_c_r <= 2'b11;
      sync_d_r <= 2'b11;
    end else begin
      sync_c_r <= {sync_c_r[0], ps2c};
      sync_d_r <= {sync_d_r[0], ps2d};
    end
  end

  // Clock de-glitch filter: the level only changes after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_sr_r   <= {FILTER_LEN{1'b1}};
      filt_c_r    <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_sr_r   <= {filt_sr_r[FILTER_LEN-2:0], sync_c_r[1]};
      filt_prev_r <= filt_c_r;
      if (filt_sr_r == {FILTER_LEN{1'b1}}) begin
        filt_c_r <= 1'b1;
      end else if (filt_sr_r == {FILTER_LEN{1'b0}}) begin
        filt_c_r <= 1'b0;
      end else begin
        filt_c_r <= filt_c_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_edge_s && rx_en && !data_s) begin
          state_nxt_s = DPS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DPS: begin
        if (fall_edge_s) begin
          if (bit_cnt_r == 4'd0) begin
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = DPS;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DPS;
        end
      end
      LOAD: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM output and datapath logic. The frame verdict is taken on the stop-bit edge so
  // the registered pulse and dout are visible during the single LOAD cycle.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    shreg_nxt_s   = shreg_r;
    dout_nxt_s    = dout_r;
    done_nxt_s    = 1'b0;
    perr_nxt_s    = 1'b0;
    ferr_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_edge_s && rx_en && !data_s) begin
          bit_cnt_nxt_s = 4'd9;
          tmo_cnt_nxt_s = {TMO_W{1'b0}};
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
          tmo_cnt_nxt_s = tmo_cnt_r;
        end
      end
      DPS: begin
        if (fall_edge_s) begin
          shreg_nxt_s   = frame_s[9:1];
          tmo_cnt_nxt_s = {TMO_W{1'b0}};
          if (bit_cnt_r == 4'd0) begin
            bit_cnt_nxt_s = 4'd0;
            if (frame_s[9] && odd_parity_ok(frame_s[8:0])) begin
              dout_nxt_s = frame_s[7:0];
              done_nxt_s = 1'b1;
            end else if (!odd_parity_ok(frame_s[8:0])) begin
              perr_nxt_s = 1'b1;
            end else begin
              ferr_nxt_s = 1'b1;
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r - 4'd1;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          ferr_nxt_s    = 1'b1;
          tmo_cnt_nxt_s = {TMO_W{1'b0}};
          bit_cnt_nxt_s = 4'd0;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      LOAD: begin
        bit_cnt_nxt_s = 4'd0;
        tmo_cnt_nxt_s = {TMO_W{1'b0}};
      end
      default: begin
        bit_cnt_nxt_s = 4'd0;
        tmo_cnt_nxt_s = {TMO_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 4'd0;
      tmo_cnt_r <= {TMO_W{1'b0}};
      shreg_r   <= 9'h000;
      dout_r    <= 8'h00;
      done_r    <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      shreg_r   <= shreg_nxt_s;
      dout_r    <= dout_nxt_s;
      done_r    <= done_nxt_s;
      perr_r    <= perr_nxt_s;
      ferr_r    <= ferr_nxt_s;
    end
  end

  assign rx_done_tick = done_r;
  assign dout         = dout_r;
  assign parity_err   = perr_r;
  assign frame_err    = ferr_r;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven on ps2c/ps2d, expected pulses are
// queued at drive time and matched when the receiver reports.
module tb_ps2_rx;

  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 100;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_FERR = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  longint     cyc = 0;
  longint     last_fall_cyc = 0;
  logic [7:0] exp_dout = 8'h00;

  ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive nbits of a frame (start, D0..D7, parity, stop) and queue its expected outcome.
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                            input int nbits, input int drop_en_after, input int gap);
    logic [10:0] fr;
    logic        par;
    logic        en0;
    exp_t        e;
    par = (~^data) ^ par_flip;
    fr  = {stop, par, data, 1'b0};
    en0 = rx_en;
    if (en0 && nbits == 11) begin
      e.data = data;
      e.tmo  = 1'b0;
      if (stop && !par_flip) e.kind = K_DONE;
      else if (par_flip)     e.kind = K_PERR;
      else                   e.kind = K_FERR;
      sb_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_en_after) rx_en = 1'b0;
      ps2d = fr[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, {31'd0, rx_done_tick}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_dout"}, {24'd0, dout}, 32'd0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t   e;
    longint dl;
    cyc <= cyc + 1;
    if (reset && (rx_done_tick || parity_err || frame_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, frame_err, parity_err, rx_done_tick}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", {29'd0, frame_err, parity_err, rx_done_tick}, {29'd0, e.kind});
        if (e.kind == K_DONE) exp_dout = e.data;
        check("dout", {24'd0, dout}, {24'd0, exp_dout});
        if (e.tmo) begin
          dl = cyc - last_fall_cyc;
          check("tmo_latency_ok", {31'd0, (dl >= TMO && dl <= TMO + 30)}, 32'd1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (50) @(negedge clk);

    // Good frame, then back-to-back pair one bit time apart.
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 400);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 2 * HALF);
    send_frame(8'h75, 1'b0, 1'b1, 11, -1, 400);
    check("dout_after_pair", {24'd0, dout}, 32'h75);

    // Parity error, then stop-bit error; dout must hold 8'h75.
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 400);
    send_frame(8'h72, 1'b0, 1'b0, 11, -1, 400);
    check("dout_after_errs", {24'd0, dout}, 32'h75);

    // Stall after five clock edges: timeout frame_err, then a good frame.
    e.kind = K_FERR; e.data = 8'h00; e.tmo = 1'b1;
    sb_q.push_back(e);
    send_frame(8'hA6, 1'b0, 1'b1, 5, -1, TMO + 300);
    send_frame(8'h6B, 1'b0, 1'b1, 11, -1, 400);

    // Sub-filter glitch while idle must do nothing.
    ps2c = 1'b0;
    repeat (FILT - 1) @(negedge clk);
    ps2c = 1'b1;
    repeat (200) @(negedge clk);

    // Disabled receiver ignores a whole frame.
    rx_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 11, -1, 400);
    rx_en = 1'b1;
    check("dout_after_disabled", {24'd0, dout}, 32'h6B);

    // rx_en drops after the third bit: frame still completes.
    send_frame(8'hA5, 1'b0, 1'b1, 11, 3, 400);
    rx_en = 1'b1;
    check("dout_after_en_drop", {24'd0, dout}, 32'hA5);

    // Reset after six data bits discards the frame; next frame received cleanly.
    send_frame(8'h99, 1'b0, 1'b1, 7, -1, 20);
    reset = 1'b0;
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(8'h23, 1'b0, 1'b1, 11, -1, 400);
    check("dout_final", {24'd0, dout}, 32'h23);

    repeat (2000) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host serial receiver that deserializes 11-bit keyboard frames into scan-code bytes.
- Sits directly upstream of the key decoder. Its dout/rx_done_tick pair drives that stage's keycodeout/rx_done_tick inputs.
- Synchronizes and de-glitches the external ps2c/ps2d lines, detects falling edges of the filtered PS/2 clock, checks odd parity and the stop bit, and aborts stalled frames on timeout.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized ps2c samples required to change the filtered clock level.
- TIMEOUT_CYC, 200000: clk cycles with no filtered falling edge while a frame is in progress before the frame is aborted (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2c  in  1  raw PS/2 clock line from the pad.
- ps2d  in  1  raw PS/2 data line from the pad.
- rx_en  in  1  1 = a new frame may start; has no effect on a frame already in progress.
- rx_done_tick  out  1  one-cycle pulse; dout holds a valid new byte.
- dout  out  8  last correctly received data byte.
- parity_err  out  1  one-cycle pulse; frame rejected for parity.
- frame_err  out  1  one-cycle pulse; frame rejected for a bad stop bit or a timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; bit counter and timeout counter clear to 0.
  - Both synchronizers and the filter shift register load all ones; filtered clock = 1.
  - dout=8'h00; rx_done_tick=0, parity_err=0, frame_err=0.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchronizer.
  - Synchronized ps2c shifts into a FILTER_LEN-bit register. Filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - fall_edge = filtered clock 1 in the previous cycle and 0 in the current cycle. It is a single-cycle strobe.
- Frame format: start bit 0, data D0..D7 (LSB first), odd parity bit, stop bit 1. Data bits are sampled from synchronized ps2d in the cycle fall_edge is asserted.
- FSM states:
  - IDLE: on fall_edge with rx_en=1 and ps2d=0, go to DPS with bit counter=9 and timeout counter cleared.
    - fall_edge with ps2d=1 (false start) is ignored.
    - fall_edge with rx_en=0 is ignored.
  - DPS: on each fall_edge, shift the sample into a 10-bit register MSB-in ({ps2d, reg[9:1]}) and clear the timeout counter.
    - If the bit counter is 0, go to LOAD; otherwise decrement it.
    - With no fall_edge, increment the timeout counter. When it reaches TIMEOUT_CYC-1, pulse frame_err for one cycle, go to IDLE, leave dout unchanged.
  - LOAD (exactly one cycle, then IDLE unconditionally):
    - If stop=1 and XOR of the 8 data bits and the parity bit = 1: dout <= data and rx_done_tick=1.
    - Else if the parity check fails: parity_err=1, dout unchanged.
    - Else (stop=0): frame_err=1, dout unchanged.
    - If both the parity check and the stop bit fail, only parity_err pulses.
- Output timing: rx_done_tick and the new dout value appear together, registered, one clk after the fall_edge of the stop bit. dout stays stable until the next good frame.
- Pulse exclusivity: rx_done_tick, parity_err and frame_err are never asserted in the same cycle. Each pulse lasts exactly one cycle.
- Back-to-back frames: a start-bit fall_edge arriving in the cycle the FSM returns to IDLE is accepted.
- Boundary conditions:
  - rx_en dropping mid-frame: the frame completes normally.
  - reset asserted mid-frame: the partial frame is discarded with no pulses; after release the next start bit is required.
  - ps2c glitch low for fewer than FILTER_LEN consecutive samples: no fall_edge is produced.
- Widths: the timeout counter is sized as ceil(log2(TIMEOUT_CYC)) bits; the bit counter is 4 bits.

Test Plan:
- Good frame: byte 8'h1C with parity 0 and stop 1, PS/2 clock period 80 us, rx_en=1 -> exactly one rx_done_tick, dout=8'h1C, no error pulses.
- Back-to-back frames: 8'hF0 (parity 1) then 8'h75 (parity 0) separated by 1 bit time -> two rx_done_ticks, dout=8'hF0 then 8'h75.
- Parity error: byte 8'h1C sent with parity 1 -> single parity_err pulse, no rx_done_tick, dout keeps its previous value.
- Stop-bit error and timeout:
  - Byte 8'h72 with stop bit 0 -> single frame_err pulse, no rx_done_tick.
  - With TIMEOUT_CYC=1000, stop ps2c after 5 bits -> frame_err pulse 1000 cycles after the last edge. A subsequent good 8'h6B frame is then received correctly.
- Glitch and enable:
  - ps2c pulses low for FILTER_LEN-1 cycles while idle -> no state change, no pulses.
  - rx_en=0 during a start bit -> frame ignored.
  - rx_en dropped after the 3rd bit -> the frame still completes.
- Reset mid-frame: assert reset after 6 data bits, release it, then send 8'h23 -> only one rx_done_tick with dout=8'h23; all outputs are 0 during reset.
